draw_index_gen: RTL
===================

Name: draw_index_gen

Overview:
- Upstream feeder of the free-memory manager in the lottery draw path.
- On each draw request, produces a uniform-ish random index AdModulo in [0, SIZE_MEM-1-AdMax] and keeps the drawn-count AdMax.
- The manager swaps the drawn slot with the last free slot, giving draw-without-replacement.
- Also sequences the manager's memory (re)initialisation at power-up and new game.

Parameters:
- SIZE_MEM, 90: number of lottery values / manager memory depth; must match the manager.
- MAX_DRAWS, 10: draws per game; 1 ≤ MAX_DRAWS ≤ SIZE_MEM-1.
- HOLD_CYCLES, 12: Clk cycles AdModulo is held with old AdMax while the manager performs its swap (manager needs 11 negedges).
- INIT_CYCLES, 400: Clk cycles waited after MemReset for the manager's fill loop (4 states × 90 entries + margin).

Ports:
- Clk  in  1  system clock; all logic on posedge (the manager samples on negedge).
- Reset  in  1  asynchronous, active-low reset.
- Draw  in  1  draw request, sampled in IDLE only.
- NewGame  in  1  start a new game, sampled in IDLE only.
- AdModulo  out  7  random index to the manager.
- AdMax  out  7  number of draws completed in the current game.
- MemReset  out  1  active-high init request to the manager.
- Busy  out  1  high in every state except IDLE.
- DrawDone  out  1  one-cycle pulse when a draw commits.
- GameOver  out  1  high while AdMax == MAX_DRAWS.

Behaviour:
- Reset values while Reset = 0: AdModulo = 0, AdMax = 0, MemReset = 0, Busy = 0, DrawDone = 0, GameOver = 0, LFSR = 16'hACE1, state = INIT.
- Reset asserted mid-operation aborts immediately; on release the block re-runs INIT.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every cycle including IDLE. Never zero.
- State INIT (2 cycles): MemReset = 1, Busy = 1, AdMax cleared. Then INIT_WAIT.
- INIT_WAIT: MemReset = 0, counts INIT_CYCLES cycles, then IDLE.
- IDLE: Busy = 0.
  - NewGame = 1 → INIT. NewGame has priority over Draw.
  - Draw = 1 and GameOver = 0 → LOAD.
  - Draw with GameOver = 1 is ignored; no DrawDone.
  - Draw/NewGame while Busy are ignored, not queued.
- LOAD (1 cycle): acc (8 bit) = LFSR[7:0]; rem (7 bit) = SIZE_MEM - AdMax. rem ≥ 2 is guaranteed by the MAX_DRAWS limit.
- MOD: while acc ≥ rem, acc = acc - rem, one subtraction per cycle; at most 255 cycles. Leaves when acc < rem.
- CHECK (1 cycle): if acc == current AdModulo, acc = (acc+1 == rem) ? 0 : acc+1.
  - Rationale: the manager triggers only on an AdModulo change, so consecutive equal indices would be lost.
  - rem ≥ 2 guarantees the adjusted value differs.
- PRESENT (1 cycle): AdModulo = acc[6:0]. AdModulo changes only here and at reset.
- HOLD: HOLD_CYCLES cycles; AdModulo and AdMax frozen.
- COMMIT (1 cycle): AdMax = AdMax+1, DrawDone = 1 for this cycle. GameOver updates the same cycle. → IDLE.
- Draw latency from the Draw sample to DrawDone: 1 + k + 1 + 1 + HOLD_CYCLES + 1 cycles, where k = number of subtractions.
- Outputs are registered; AdModulo is stable across the manager's negedge.

Decomposition:
- Shared package: SIZE_MEM, MAX_DRAWS default, state encoding constants (INIT, INIT_WAIT, IDLE, LOAD, MOD, CHECK, PRESENT, HOLD, COMMIT), LFSR seed and tap mask.
- One natural sub-module: lfsr16 (Clk, Reset, free-running 16-bit output).
- The modulo subtractor stays inline in the FSM.

Test Plan:
- Power-up: Reset low 3 cycles, then high → MemReset = 1 for exactly cycles 1-2 after release. Busy = 1 for 2+400 cycles. Then Busy = 0, AdMax = 0, AdModulo = 0.
- Single draw at defaults: Draw pulse in IDLE → AdModulo ∈ [0,89] and changes value. AdMax stays 0 for 12 cycles after the change. Then DrawDone pulses once and AdMax = 1. Latency matches the formula, with k checked against the LFSR model.
- Full game: 10 draws → AdModulo of draw n ∈ [0, 90-n]. AdModulo never equals its previous value. After the 10th draw GameOver = 1. An 11th Draw gives no state change and no DrawDone.
- Collision rule: SIZE_MEM = 2, MAX_DRAWS = 1, AdModulo = 0 → after Draw, AdModulo = 1 regardless of LFSR value.
- Priority/busy: Draw and NewGame asserted together in IDLE → INIT entered, MemReset pulses, AdMax = 0. A Draw asserted during HOLD is ignored; exactly one DrawDone.
- Reset mid-draw: Reset low during MOD → all outputs return to reset values immediately. On release INIT re-runs and no DrawDone is produced.

Source files
------------

// File: rtl/draw_index_gen_pkg.sv
// Shared constants, state encoding and LFSR helper for the lottery draw index generator.
package draw_index_gen_pkg;

  localparam int SIZE_MEM_DEF    = 90;
  localparam int MAX_DRAWS_DEF   = 10;
  localparam int HOLD_CYCLES_DEF = 12;
  localparam int INIT_CYCLES_DEF = 400;

  localparam int IDX_W = 7;
  localparam int CNT_W = 16;

  // Taps x^16+x^14+x^13+x^11+1 in right-shifting form land on bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [3:0] {
    INIT,
    INIT_WAIT,
    IDLE,
    LOAD,
    MOD,
    CHECK,
    PRESENT,
    HOLD,
    COMMIT
  } drawState_t;

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/draw_index_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances on every clock once out of reset.
module draw_index_gen_lfsr16
  import draw_index_gen_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [OUT_W-1:0] Value
);

  logic [15:0] valueReg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valueReg <= LFSR_SEED;
    end else begin
      valueReg <= lfsrStep(valueReg);
    end
  end

  assign Value = valueReg[OUT_W-1:0];

endmodule

// File: rtl/draw_index_gen.sv
// Draw sequencer: reduces an LFSR byte modulo the free-slot count, presents it to the
// free-memory manager, holds it through the manager's swap, then commits the draw.
module draw_index_gen
  import draw_index_gen_pkg::*;
#(
  parameter int SIZE_MEM    = SIZE_MEM_DEF,
  parameter int MAX_DRAWS   = MAX_DRAWS_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Draw,
  input  logic             NewGame,
  output logic [IDX_W-1:0] AdModulo,
  output logic [IDX_W-1:0] AdMax,
  output logic             MemReset,
  output logic             Busy,
  output logic             DrawDone,
  output logic             GameOver
);

  localparam logic [IDX_W-1:0] SIZE_MEM_V  = IDX_W'(SIZE_MEM);
  localparam logic [IDX_W-1:0] MAX_DRAWS_V = IDX_W'(MAX_DRAWS);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  drawState_t       stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [7:0]       accReg, accNext;
  logic [IDX_W-1:0] remReg, remNext;
  logic [IDX_W-1:0] adModuloReg, adModuloNext;
  logic [IDX_W-1:0] adMaxReg, adMaxNext;
  logic             memResetReg, memResetNext;
  logic             busyReg, busyNext;
  logic             drawDoneReg, drawDoneNext;
  logic             gameOverReg, gameOverNext;

  logic [7:0]       lfsrLow;
  logic [IDX_W-1:0] loadRem;
  logic [7:0]       rem8;
  logic [7:0]       accMinusRem;
  logic [7:0]       accPlusOne;
  logic [IDX_W-1:0] adMaxPlusOne;
  logic             reqOk;

  draw_index_gen_lfsr16 #(.OUT_W(8)) uLfsr (
    .Clk  (Clk),
    .Reset(Reset),
    .Value(lfsrLow)
  );

  assign loadRem      = SIZE_MEM_V - adMaxReg;
  assign rem8         = {1'b0, remReg};
  assign accMinusRem  = accReg - rem8;
  assign accPlusOne   = accReg + 8'd1;
  assign adMaxPlusOne = adMaxReg + 7'd1;
  // Requests count only when the outside world can see Busy low.
  assign reqOk        = (stateReg == IDLE) && !busyReg;

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    accNext      = accReg;
    remNext      = remReg;
    adModuloNext = adModuloReg;
    adMaxNext    = adMaxReg;
    gameOverNext = gameOverReg;
    memResetNext = 1'b0;
    drawDoneNext = 1'b0;
    busyNext     = (stateReg != IDLE);
    case (stateReg)
      INIT: begin
        memResetNext = 1'b1;
        adMaxNext    = '0;
        gameOverNext = 1'b0;
        if (cntReg == CNT_W'(1)) begin
          cntNext   = '0;
          stateNext = INIT_WAIT;
        end else begin
          cntNext = cntReg + CNT_W'(1);
        end
      end
      INIT_WAIT: begin
        if (cntReg == INIT_LAST) begin
          cntNext   = '0;
          stateNext = IDLE;
        end else begin
          cntNext = cntReg + CNT_W'(1);
        end
      end
      IDLE: begin
        if (reqOk) begin
          if (NewGame) begin
            stateNext = INIT;
            busyNext  = 1'b1;
          end else if (Draw && !gameOverReg) begin
            stateNext = LOAD;
            busyNext  = 1'b1;
          end
        end
      end
      LOAD: begin
        accNext   = lfsrLow;
        remNext   = loadRem;
        stateNext = (lfsrLow >= {1'b0, loadRem}) ? MOD : CHECK;
      end
      MOD: begin
        accNext = accMinusRem;
        if (accMinusRem < rem8) begin
          stateNext = CHECK;
        end
      end
      CHECK: begin
        // The manager reacts only to a change, so a repeated index is bumped by one.
        if (accReg == {1'b0, adModuloReg}) begin
          accNext = (accPlusOne == rem8) ? 8'd0 : accPlusOne;
        end
        stateNext = PRESENT;
      end
      PRESENT: begin
        adModuloNext = accReg[IDX_W-1:0];
        stateNext    = HOLD;
      end
      HOLD: begin
        if (cntReg == HOLD_LAST) begin
          cntNext   = '0;
          stateNext = COMMIT;
        end else begin
          cntNext = cntReg + CNT_W'(1);
        end
      end
      COMMIT: begin
        adMaxNext    = adMaxPlusOne;
        gameOverNext = (adMaxPlusOne == MAX_DRAWS_V);
        drawDoneNext = 1'b1;
        stateNext    = IDLE;
      end
      default: begin
        cntNext   = '0;
        stateNext = INIT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg    <= INIT;
      cntReg      <= '0;
      accReg      <= '0;
      remReg      <= '0;
      adModuloReg <= '0;
      adMaxReg    <= '0;
      memResetReg <= 1'b0;
      busyReg     <= 1'b0;
      drawDoneReg <= 1'b0;
      gameOverReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      accReg      <= accNext;
      remReg      <= remNext;
      adModuloReg <= adModuloNext;
      adMaxReg    <= adMaxNext;
      memResetReg <= memResetNext;
      busyReg     <= busyNext;
      drawDoneReg <= drawDoneNext;
      gameOverReg <= gameOverNext;
    end
  end

  assign AdModulo = adModuloReg;
  assign AdMax    = adMaxReg;
  assign MemReset = memResetReg;
  assign Busy     = busyReg;
  assign DrawDone = drawDoneReg;
  assign GameOver = gameOverReg;

endmodule
